disp_hole_fill: RTL and testbench
=================================

// Module: disp_hole_fill
// PURPOSE
//   Post-LRCC disparity stage that consumes the disparity stream from stereo_match (o_dval/o_data).
//   Fills pixels rejected by the LRCC check (disparity == INV) with the last valid disparity on the same line.
//   A hole is filled only while it is no longer than MAX_GAP pixels.
//   Tracks column/row position and emits start/end-of-line and start/end-of-frame markers for the display/DMA stage.
// PARAMETERS
//   D        64   disparity range; DBIT = $clog2(D)
//   M        450  valid disparity pixels per line
//   ROWS     375  lines per frame
//   INV      0    disparity code marking an LRCC-rejected pixel
//   MAX_GAP  16   longest hole (pixels) that is filled; GBIT = $clog2(MAX_GAP+1)
// PORTS
//   i_clk      in   1     clock, all logic on rising edge
//   i_rst      in   1     synchronous reset, active-high
//   i_dval     in   1     input disparity valid (one pixel per asserted cycle, gaps allowed)
//   i_data     in   DBIT  input disparity
//   i_fill_en  in   1     1 = hole filling on; 0 = bypass (data passed unchanged, markers still generated)
//   o_dval     out  1     output valid
//   o_data     out  DBIT  output disparity
//   o_filled   out  1     o_data is a substituted value
//   o_sol      out  1     first pixel of line (qualified by o_dval)
//   o_eol      out  1     last pixel of line
//   o_sof      out  1     first pixel of frame
//   o_eof      out  1     last pixel of frame
// BEHAVIOUR
//   - Reset (i_rst=1 at a clock edge):
//     - all outputs forced to 0; o_data=0
//     - col=0, row=0, last_valid=INV, have_valid=0, gap_cnt=0
//     - reset mid-line/mid-frame discards position; the next i_dval pixel is col 0 / row 0
//   - Latency: exactly 1 cycle, registered outputs.
//     - o_dval(t+1) = i_dval(t)
//     - all other outputs update only on i_dval cycles and hold their value otherwise
//   - Position counters, advanced on each i_dval:
//     - col counts 0..M-1; on col==M-1 wraps to 0 and row increments
//     - row counts 0..ROWS-1; on row==ROWS-1 with col==M-1 wraps to 0
//   - Markers, registered with the pixel:
//     - o_sol: col==0;  o_eol: col==M-1
//     - o_sof: col==0 && row==0;  o_eof: col==M-1 && row==ROWS-1
//   - Fill state per line: last_valid (DBIT), have_valid (1), gap_cnt (GBIT, saturates at MAX_GAP+1).
//     - On a pixel with col==0: state is evaluated as cleared (have_valid=0, gap_cnt=0) before processing, so no value crosses lines.
//   - Valid pixel (i_data != INV):
//     - o_data=i_data, o_filled=0
//     - last_valid<=i_data, have_valid<=1, gap_cnt<=0
//   - Hole pixel (i_data == INV): gap_cnt increments (saturating); n = gap_cnt after increment.
//     - i_fill_en=1 && have_valid && n<=MAX_GAP: o_data=last_valid, o_filled=1
//     - otherwise: o_data=INV, o_filled=0
//     - once n exceeds MAX_GAP, the remainder of that hole is INV even though earlier pixels were filled (left-only causal fill, no lookahead)
//   - Bypass (i_fill_en=0):
//     - o_data=i_data, o_filled=0
//     - fill state keeps updating, so re-enabling mid-line is consistent
//     - i_fill_en is sampled per pixel
//   - Idle cycles (i_dval=0) change no state except o_dval.
// TESTING
//   T1 reset: assert i_rst 2 cycles with i_dval=1 -> o_dval=0, o_data=0, all markers 0; first post-reset pixel gives o_sol=o_sof=1.
//   T2 passthrough: line 5,6,7,...(all !=INV), fill_en=1 -> o_data equals input 1 cycle later, o_filled=0, o_eol on 450th pixel.
//   T3 short hole: 9,0,0,0,12 -> 9,9,9,9,12 with o_filled=0,1,1,1,0.
//   T4 long hole (MAX_GAP=16): 20 then 18 zeros -> 16x 20 (filled), then 2x 0 (o_filled=0).
//   T5 line start: previous line ends with 30; new line starts 0,0,8 -> 0,0,8 and o_filled=0 (no cross-line fill); same input with fill_en=0 -> unchanged.
//   T6 frame wrap + gaps: 450*375 pixels with random i_dval gaps -> one o_sof, one o_eof at the last pixel, next pixel o_sof=1; mid-frame i_rst -> next pixel col0/row0.

Source files
------------

// File: rtl/disp_hole_fill.sv
// Post-LRCC disparity hole filler: replaces rejected pixels with the last valid
// disparity on the same line (bounded gap) and tags line/frame boundaries.
module disp_hole_fill #(
  parameter int D       = 64,
  parameter int M       = 450,
  parameter int ROWS    = 375,
  parameter int INV     = 0,
  parameter int MAX_GAP = 16,
  localparam int DBIT   = $clog2(D),
  localparam int GBIT   = $clog2(MAX_GAP + 1),
  localparam int CBIT   = $clog2(M + 1),
  localparam int RBIT   = $clog2(ROWS + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_dval,
  input  logic [DBIT-1:0] i_data,
  input  logic            i_fill_en,
  output logic            o_dval,
  output logic [DBIT-1:0] o_data,
  output logic            o_filled,
  output logic            o_sol,
  output logic            o_eol,
  output logic            o_sof,
  output logic            o_eof
);

  logic [CBIT-1:0] col_r;
  logic [RBIT-1:0] row_r;
  logic [DBIT-1:0] last_valid_r;
  logic            have_valid_r;
  logic [GBIT-1:0] gap_cnt_r;

  logic            line_start_s;
  logic            col_last_s;
  logic            row_last_s;
  logic            is_hole_s;
  logic            have_valid_s;
  logic [GBIT-1:0] gap_eff_s;
  logic [GBIT-1:0] gap_next_s;
  logic            fill_s;
  logic [DBIT-1:0] data_s;
  logic [CBIT-1:0] col_next_s;
  logic [RBIT-1:0] row_next_s;

  // Per-pixel fill decision and position advance
  always_comb begin
    line_start_s = (col_r == CBIT'(0));
    col_last_s   = (col_r == CBIT'(M - 1));
    row_last_s   = (row_r == RBIT'(ROWS - 1));
    is_hole_s    = (i_data == DBIT'(INV));
    // Fill state is treated as cleared at column 0 so nothing leaks across lines
    have_valid_s = line_start_s ? 1'b0 : have_valid_r;
    gap_eff_s    = line_start_s ? GBIT'(0) : gap_cnt_r;
    if (gap_eff_s == GBIT'(MAX_GAP + 1)) begin
      gap_next_s = gap_eff_s;
    end else begin
      gap_next_s = gap_eff_s + GBIT'(1);
    end
    fill_s = i_fill_en & have_valid_s & is_hole_s & (gap_next_s <= GBIT'(MAX_GAP));
    // An unfilled hole already carries INV, so passing i_data covers both cases
    data_s = fill_s ? last_valid_r : i_data;
    if (col_last_s) begin
      col_next_s = CBIT'(0);
      row_next_s = row_last_s ? RBIT'(0) : row_r + RBIT'(1);
    end else begin
      col_next_s = col_r + CBIT'(1);
      row_next_s = row_r;
    end
  end

  // State and registered outputs; only o_dval moves on idle cycles
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col_r        <= CBIT'(0);
      row_r        <= RBIT'(0);
      last_valid_r <= DBIT'(INV);
      have_valid_r <= 1'b0;
      gap_cnt_r    <= GBIT'(0);
      o_dval       <= 1'b0;
      o_data       <= DBIT'(0);
      o_filled     <= 1'b0;
      o_sol        <= 1'b0;
      o_eol        <= 1'b0;
      o_sof        <= 1'b0;
      o_eof        <= 1'b0;
    end else begin
      o_dval <= i_dval;
      if (i_dval) begin
        o_data   <= data_s;
        o_filled <= fill_s;
        o_sol    <= line_start_s;
        o_eol    <= col_last_s;
        o_sof    <= line_start_s & (row_r == RBIT'(0));
        o_eof    <= col_last_s & row_last_s;
        col_r    <= col_next_s;
        row_r    <= row_next_s;
        if (is_hole_s) begin
          have_valid_r <= have_valid_s;
          gap_cnt_r    <= gap_next_s;
        end else begin
          last_valid_r <= i_data;
          have_valid_r <= 1'b1;
          gap_cnt_r    <= GBIT'(0);
        end
      end
    end
  end

endmodule

// File: tb/tb_disp_hole_fill.sv
// Directed self-checking bench for disp_hole_fill (frame height reduced to keep
// the full-frame wrap test short).
module tb_disp_hole_fill;
  localparam int M    = 450;
  localparam int ROWS = 4;
  localparam int DBIT = 6;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_dval = 1'b0;
  logic [DBIT-1:0] i_data = '0;
  logic            i_fill_en = 1'b1;
  logic            o_dval;
  logic [DBIT-1:0] o_data;
  logic            o_filled, o_sol, o_eol, o_sof, o_eof;

  int checks = 0;
  int errors = 0;
  int tb_col = 0;
  int tb_row = 0;
  int p_col, p_row;

  disp_hole_fill #(.D(64), .M(M), .ROWS(ROWS), .INV(0), .MAX_GAP(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_dval(i_dval), .i_data(i_data),
    .i_fill_en(i_fill_en), .o_dval(o_dval), .o_data(o_data),
    .o_filled(o_filled), .o_sol(o_sol), .o_eol(o_eol), .o_sof(o_sof),
    .o_eof(o_eof)
  );

  always #5 i_clk = ~i_clk;

  // Drive one pixel at a falling edge; its outputs are visible at the next one.
  task automatic pix(input logic [DBIT-1:0] d, input logic fe);
    i_dval = 1'b1; i_data = d; i_fill_en = fe;
    p_col = tb_col; p_row = tb_row;
    @(negedge i_clk);
    if (tb_col == M - 1) begin
      tb_col = 0;
      tb_row = (tb_row == ROWS - 1) ? 0 : tb_row + 1;
    end else begin
      tb_col = tb_col + 1;
    end
  endtask

  task automatic idle(input int n);
    i_dval = 1'b0;
    repeat (n) @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_dval = 1'b0; i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0; tb_col = 0; tb_row = 0;
  endtask

  task automatic pad_line_end(input logic [DBIT-1:0] last);
    while (tb_col != M - 1) pix(6'd3, 1'b1);
    pix(last, 1'b1);
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_dval = 1'b1; i_data = 6'd5; i_fill_en = 1'b1;
    repeat (2) @(negedge i_clk);
    checks++;
    if ({o_dval, o_filled, o_sol, o_eol, o_sof, o_eof, o_data} !== 12'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0", {o_dval, o_filled, o_sol, o_eol, o_sof, o_eof, o_data});
    end
    i_rst = 1'b0; tb_col = 0; tb_row = 0;
    pix(6'd7, 1'b1);
    checks++;
    if ({o_dval, o_sol, o_sof, o_eol, o_eof, o_filled} !== 6'b111000) begin
      errors++;
      $display("FAIL first_pixel_markers got %b want 111000", {o_dval, o_sol, o_sof, o_eol, o_eof, o_filled});
    end
    checks++;
    if (o_data !== 6'd7) begin
      errors++; $display("FAIL first_pixel_data got %0d want 7", o_data);
    end
  endtask

  task automatic test_hold();
    idle(2);
    checks++;
    if ({o_dval, o_sol, o_sof, o_data} !== {1'b0, 1'b1, 1'b1, 6'd7}) begin
      errors++;
      $display("FAIL idle_hold got dval=%b sol=%b sof=%b data=%0d want 0 1 1 7", o_dval, o_sol, o_sof, o_data);
    end
  endtask

  task automatic test_passthrough();
    int n = 0;
    int eol_cnt = 0;
    logic [DBIT-1:0] d;
    do begin
      d = DBIT'(5 + (n % 50));
      pix(d, 1'b1);
      n++;
      if (o_eol) eol_cnt++;
      checks++;
      if (o_data !== d || o_filled !== 1'b0 || o_dval !== 1'b1) begin
        errors++;
        $display("FAIL pass_data col %0d got %0d/%b want %0d/0", p_col, o_data, o_filled, d);
      end
      checks++;
      if (o_eol !== (p_col == M - 1) || o_sol !== (p_col == 0)) begin
        errors++;
        $display("FAIL pass_markers col %0d got eol=%b sol=%b", p_col, o_eol, o_sol);
      end
    end while (tb_col != 0);
    checks++;
    if (eol_cnt != 1) begin
      errors++; $display("FAIL pass_eol_count got %0d want 1", eol_cnt);
    end
  endtask

  task automatic test_short_hole();
    logic [DBIT-1:0] din [5];
    logic [DBIT-1:0] dex [5];
    logic            fex [5];
    din = '{6'd9, 6'd0, 6'd0, 6'd0, 6'd12};
    dex = '{6'd9, 6'd9, 6'd9, 6'd9, 6'd12};
    fex = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      pix(din[i], 1'b1);
      checks++;
      if (o_data !== dex[i] || o_filled !== fex[i]) begin
        errors++;
        $display("FAIL short_hole[%0d] got %0d/%b want %0d/%b", i, o_data, o_filled, dex[i], fex[i]);
      end
    end
  endtask

  task automatic test_long_hole();
    pix(6'd20, 1'b1);
    checks++;
    if (o_data !== 6'd20 || o_filled !== 1'b0) begin
      errors++; $display("FAIL long_hole_head got %0d/%b want 20/0", o_data, o_filled);
    end
    for (int i = 0; i < 18; i++) begin
      pix(6'd0, 1'b1);
      checks++;
      if (o_data !== ((i < 16) ? 6'd20 : 6'd0) || o_filled !== (i < 16)) begin
        errors++;
        $display("FAIL long_hole[%0d] got %0d/%b want %0d/%b", i, o_data, o_filled, (i < 16) ? 20 : 0, i < 16);
      end
    end
  endtask

  task automatic test_line_start();
    logic [DBIT-1:0] din [3];
    din = '{6'd0, 6'd0, 6'd8};
    for (int pass = 0; pass < 2; pass++) begin
      pad_line_end(6'd30);
      for (int i = 0; i < 3; i++) begin
        pix(din[i], (pass == 0));
        checks++;
        if (o_data !== din[i] || o_filled !== 1'b0) begin
          errors++;
          $display("FAIL line_start p%0d[%0d] got %0d/%b want %0d/0", pass, i, o_data, o_filled, din[i]);
        end
      end
    end
  endtask

  task automatic test_bypass();
    pix(6'd9, 1'b0);
    pix(6'd0, 1'b0);
    checks++;
    if (o_data !== 6'd0 || o_filled !== 1'b0) begin
      errors++; $display("FAIL bypass_hole got %0d/%b want 0/0", o_data, o_filled);
    end
    pix(6'd0, 1'b1);
    checks++;
    if (o_data !== 6'd9 || o_filled !== 1'b1) begin
      errors++; $display("FAIL bypass_reenable got %0d/%b want 9/1", o_data, o_filled);
    end
    pix(6'd11, 1'b0);
    checks++;
    if (o_data !== 6'd11 || o_filled !== 1'b0) begin
      errors++; $display("FAIL bypass_valid got %0d/%b want 11/0", o_data, o_filled);
    end
  endtask

  task automatic test_frame();
    int sof_cnt = 0;
    int eof_cnt = 0;
    int eof_last = 0;
    logic [DBIT-1:0] d;
    do_reset();
    for (int n = 0; n < M * ROWS; n++) begin
      d = DBIT'(5 + (n % 50));
      pix(d, 1'b1);
      if (o_sof) sof_cnt++;
      if (o_eof) begin
        eof_cnt++;
        if (n == M * ROWS - 1) eof_last = 1;
      end
      checks++;
      if (o_data !== d || o_sof !== (p_col == 0 && p_row == 0) ||
          o_eof !== (p_col == M - 1 && p_row == ROWS - 1)) begin
        errors++;
        $display("FAIL frame_pixel r%0d c%0d got %0d sof=%b eof=%b want %0d", p_row, p_col, o_data, o_sof, o_eof, d);
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    checks++;
    if (sof_cnt != 1 || eof_cnt != 1 || eof_last != 1) begin
      errors++;
      $display("FAIL frame_counts got sof=%0d eof=%0d last=%0d want 1 1 1", sof_cnt, eof_cnt, eof_last);
    end
    pix(6'd9, 1'b1);
    checks++;
    if (o_sof !== 1'b1 || o_sol !== 1'b1) begin
      errors++; $display("FAIL frame_wrap_sof got sof=%b sol=%b want 1 1", o_sof, o_sol);
    end
    repeat (600) pix(6'd6, 1'b1);
    do_reset();
    pix(6'd4, 1'b1);
    checks++;
    if ({o_sol, o_sof, o_eol, o_eof} !== 4'b1100 || o_data !== 6'd4) begin
      errors++;
      $display("FAIL midframe_reset got markers=%b data=%0d want 1100 4", {o_sol, o_sof, o_eol, o_eof}, o_data);
    end
  endtask

  initial begin
    @(negedge i_clk);
    test_reset();
    test_hold();
    test_passthrough();
    test_short_hole();
    test_long_hole();
    test_line_start();
    test_bypass();
    test_frame();
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
